// File: rtl/factorial_pkg.sv
// Shared FSM state encoding for the iterative factorial engine.
`default_nettype none

package factorial_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_MULT = 3'd1;
  localparam logic [STATE_W-1:0] S_DONE = 3'd2;

endpackage

`default_nettype wire

// File: rtl/factorial_mul_step.sv
// One multiply step: acc*cnt at full width, truncated product plus overflow flag.
`default_nettype none

module factorial_mul_step #(
  parameter int SIZE    = 8,
  parameter int N_WIDTH = 8
) (
  input  logic [SIZE-1:0]    acc,
  input  logic [N_WIDTH-1:0] cnt,
  output logic [SIZE-1:0]    product_lo,
  output logic               ovf
);

  logic [SIZE+N_WIDTH-1:0] w_prod;

  assign w_prod     = {{N_WIDTH{1'b0}}, acc} * {{SIZE{1'b0}}, cnt};
  assign product_lo = w_prod[SIZE-1:0];
  assign ovf        = |w_prod[SIZE+N_WIDTH-1:SIZE];

endmodule

`default_nettype wire

// File: rtl/factorial_iter.sv
// Iterative n! engine: one multiply per clock, abort, sticky overflow, optional saturation.
`default_nettype none

module factorial_iter
  import factorial_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int N_WIDTH  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                abort,
  input  logic [N_WIDTH-1:0]  n,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [SIZE-1:0]     result,
  output logic [STATE_W-1:0]  curr_state
);

  state_t              r_state;
  logic [SIZE-1:0]     r_acc;
  logic [N_WIDTH-1:0]  r_cnt;
  logic [SIZE-1:0]     r_result;
  logic                r_ovf;

  logic [SIZE-1:0]     w_prod_lo;
  logic                w_mul_ovf;

  factorial_mul_step #(
    .SIZE    (SIZE),
    .N_WIDTH (N_WIDTH)
  ) u_mul_step (
    .acc        (r_acc),
    .cnt        (r_cnt),
    .product_lo (w_prod_lo),
    .ovf        (w_mul_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= SIZE'(1);
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_MULT: begin
          if (r_cnt < N_WIDTH'(2)) begin
            r_state  <= S_DONE;
            r_result <= r_acc;
          end else begin
            r_acc <= w_prod_lo;
            r_cnt <= r_cnt - N_WIDTH'(1);
            if (w_mul_ovf) begin
              r_ovf <= 1'b1;
              // Saturating mode finishes on the overflowing multiply itself.
              if (SATURATE) begin
                r_acc    <= '1;
                r_result <= '1;
                r_state  <= S_DONE;
              end
            end
          end
        end
        default: begin
          // IDLE, DONE and any unreachable code all accept a new start.
          if (go) begin
            r_state <= S_MULT;
            r_cnt   <= n;
            r_acc   <= SIZE'(1);
            r_ovf   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy       = (r_state == S_MULT);
  assign done       = (r_state == S_DONE);
  assign overflow   = r_ovf;
  assign result     = r_result;
  assign curr_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_factorial_iter.sv
// Self-checking bench: wrapping (dut0) and saturating (dut1) engines on shared stimulus.
`default_nettype none

module tb_factorial_iter;

  localparam int SIZE    = 8;
  localparam int N_WIDTH = 8;
  localparam int TIMEOUT = 300;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               go;
  logic               abort;
  logic [N_WIDTH-1:0] n;

  logic               busy0, done0, ovf0, busy1, done1, ovf1;
  logic [SIZE-1:0]    res0, res1;
  logic [2:0]         st0, st1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  factorial_iter #(.SIZE(SIZE), .N_WIDTH(N_WIDTH), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .n(n),
    .busy(busy0), .done(done0), .overflow(ovf0), .result(res0), .curr_state(st0)
  );

  factorial_iter #(.SIZE(SIZE), .N_WIDTH(N_WIDTH), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .n(n),
    .busy(busy1), .done(done1), .overflow(ovf1), .result(res1), .curr_state(st1)
  );

  typedef struct {
    int n;
    int r0; int o0; int l0;
    int r1; int o1; int l1;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the multiplications k = n..2 with a SIZE-bit accumulator.
  function automatic void model(input int nn, input bit sat,
                                output int res, output int ov, output int lat);
    int acc;
    int p;
    int step;
    acc  = 1;
    ov   = 0;
    step = 0;
    lat  = (nn < 2) ? 1 : nn;
    for (int k = nn; k >= 2; k--) begin
      step++;
      p = acc * k;
      if (p >= (1 << SIZE)) begin
        ov = 1;
        if (sat) begin
          res = (1 << SIZE) - 1;
          lat = step;
          return;
        end
      end
      acc = p % (1 << SIZE);
    end
    res = acc;
  endfunction

  // Pulse go for one accepting edge, then count edges until each DUT shows done.
  task automatic run_start(input int nn, output int lat0, output int lat1);
    lat0 = -1;
    lat1 = -1;
    @(negedge clk);
    n  = N_WIDTH'(nn);
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(posedge clk);
      #1;
      if (lat0 < 0 && done0) lat0 = cyc;
      if (lat1 < 0 && done1) lat1 = cyc;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
  endtask

  vec_t vecs[8];
  int   l0, l1, er, eo, el;

  initial begin
    vecs[0] = '{n:0, r0:1,   o0:0, l0:1, r1:1,   o1:0, l1:1};
    vecs[1] = '{n:1, r0:1,   o0:0, l0:1, r1:1,   o1:0, l1:1};
    vecs[2] = '{n:2, r0:2,   o0:0, l0:2, r1:2,   o1:0, l1:2};
    vecs[3] = '{n:5, r0:120, o0:0, l0:5, r1:120, o1:0, l1:5};
    vecs[4] = '{n:6, r0:208, o0:1, l0:6, r1:255, o1:1, l1:4};
    vecs[5] = '{n:3, r0:6,   o0:0, l0:3, r1:6,   o1:0, l1:3};
    vecs[6] = '{n:7, r0:176, o0:1, l0:7, r1:255, o1:1, l1:4};
    vecs[7] = '{n:8, r0:128, o0:1, l0:8, r1:255, o1:1, l1:3};

    rst_n = 1'b0;
    go    = 1'b0;
    abort = 1'b0;
    n     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", int'(st0), 0);
    check("reset_result", int'(res0), 0);
    check("reset_flags", int'({busy0, done0, ovf0}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // go held high with n=5: done after 5 edges, then immediate restart.
    @(negedge clk);
    n  = 8'd5;
    go = 1'b1;
    @(posedge clk);
    #1;
    check("held_busy_after_accept", int'(busy0), 1);
    l0 = -1;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        l0 = cyc;
        break;
      end
    end
    check("held_latency", l0, 5);
    check("held_result", int'(res0), 120);
    check("held_overflow", int'(ovf0), 0);
    check("held_state_done", int'(st0), 2);
    @(posedge clk);
    #1;
    check("held_done_pulse", int'(done0), 0);
    check("held_restart_state", int'(st0), 1);
    @(negedge clk);
    go = 1'b0;
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(posedge clk);
      #1;
      if (done0 && done1) break;
    end
    check("held_second_done", int'(done0 && done1), 1);

    for (int i = 0; i < 8; i++) begin
      run_start(vecs[i].n, l0, l1);
      check($sformatf("vec%0d_lat0", i), l0, vecs[i].l0);
      check($sformatf("vec%0d_res0", i), int'(res0), vecs[i].r0);
      check($sformatf("vec%0d_ovf0", i), int'(ovf0), vecs[i].o0);
      check($sformatf("vec%0d_lat1", i), l1, vecs[i].l1);
      check($sformatf("vec%0d_res1", i), int'(res1), vecs[i].r1);
      check($sformatf("vec%0d_ovf1", i), int'(ovf1), vecs[i].o1);
    end

    // Bring both DUTs to a known 120 result before the abort sequence.
    run_start(5, l0, l1);
    check("pre_abort_res", int'(res0), 120);

    // Abort on the second MULT edge.
    @(negedge clk);
    n  = 8'd5;
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", int'(st0), 0);
    check("abort_busy_done", int'({busy0, done0}), 0);
    check("abort_keeps_result", int'(res0), 120);
    check("abort_keeps_ovf", int'(ovf0), 0);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_idle", int'(st0), 0);
    @(negedge clk);
    abort = 1'b0;
    run_start(3, l0, l1);
    check("after_abort_lat", l0, 3);
    check("after_abort_res", int'(res0), 6);

    // Asynchronous reset between edges mid-computation.
    @(negedge clk);
    n  = 8'd6;
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(st0), 0);
    check("async_rst_result", int'(res0), 0);
    check("async_rst_flags", int'({busy0, done0, ovf0}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_start(4, l0, l1);
    check("post_rst_lat", l0, 4);
    check("post_rst_res", int'(res0), 24);
    check("post_rst_ovf", int'(ovf0), 0);

    for (int i = 0; i < 24; i++) begin
      int nn;
      nn = int'($urandom_range(0, 20));
      run_start(nn, l0, l1);
      model(nn, 1'b0, er, eo, el);
      check($sformatf("rand%0d_n%0d_res0", i, nn), int'(res0), er);
      check($sformatf("rand%0d_n%0d_ovf0", i, nn), int'(ovf0), eo);
      check($sformatf("rand%0d_n%0d_lat0", i, nn), l0, el);
      model(nn, 1'b1, er, eo, el);
      check($sformatf("rand%0d_n%0d_res1", i, nn), int'(res1), er);
      check($sformatf("rand%0d_n%0d_ovf1", i, nn), int'(ovf1), eo);
      check($sformatf("rand%0d_n%0d_lat1", i, nn), l1, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/factorial_iter.md
Name: factorial_iter

Overview:
- Parametrised iterative factorial engine; successor to factorial_top.
- Computes n! with one multiply per clock.
- Adds async reset, abort, busy status, sticky overflow detection and an optional saturating mode.
- Sits behind a go/done request interface and exposes its FSM state for debug.

Parameters:
- SIZE, 8, width of result and accumulator.
- N_WIDTH, 8, width of operand n and the down-counter.
- SATURATE, 0, 1 = on overflow force result to all-ones and finish early; 0 = continue with truncated (mod 2^SIZE) arithmetic.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- go  input  1  start request, sampled in IDLE or DONE; may be held high.
- abort  input  1  cancel the current computation.
- n  input  N_WIDTH  operand, latched when a start is accepted.
- busy  output  1  high while in MULT.
- done  output  1  high while in DONE; result and overflow are valid.
- overflow  output  1  sticky: some product exceeded 2^SIZE-1 during this run.
- result  output  SIZE  factorial result.
- curr_state  output  3  FSM state encoding.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; result=0, done=0, busy=0, overflow=0, curr_state=0; internal acc=1, cnt=0.
- States and encodings: IDLE=0, MULT=1, DONE=2; all other codes are unreachable and decode to IDLE.
- Start acceptance, on a clock edge in IDLE or DONE with go=1 and abort=0:
  - cnt<=n, acc<=1, overflow<=0, state<=MULT.
  - done drops in the same edge.
- MULT, per edge:
  - cnt<=1: state<=DONE, result<=acc.
  - cnt>=2: p=acc*cnt computed at full SIZE+N_WIDTH width. acc<=p[SIZE-1:0], cnt<=cnt-1.
  - If p[SIZE+N_WIDTH-1:SIZE]!=0, overflow<=1.
- Overflow with SATURATE=1: on that same edge acc<=all-ones, result<=all-ones, state<=DONE, overflow<=1.
- Latency: done rises max(n,1) edges after the accepting edge (n=0 and n=1 both give result 1, no overflow).
- DONE: result, overflow and done hold until the next accepted go or an abort. go held high restarts immediately, so done pulses for one cycle.
- abort=1 on any edge: state<=IDLE, done<=0, busy<=0. result and overflow keep their last values.
  - abort has priority over go and over MULT completion.
  - abort in IDLE has no effect.
- go while in MULT is ignored; there is no queueing.
- rst_n asserted mid-computation returns every output to its reset value immediately. The first start after deassertion behaves exactly as from power-up.
- busy=(state==MULT); done=(state==DONE); both are registered-state decodes with no combinational path from inputs.

Decomposition:
- Package factorial_pkg:
  - 3-bit state typedef with IDLE/MULT/DONE constants.
  - STATE_W=3.
- Natural sub-module factorial_mul_step (combinational):
  - Inputs: acc[SIZE], cnt[N_WIDTH].
  - Outputs: product_lo[SIZE], ovf.
  - Reused by the FSM in factorial_iter.

Test Plan:
- SIZE=8, reset then go=1 with n=5 held high -> done rises 5 edges after accept; result=120, overflow=0, curr_state=2; restarts next cycle.
- n=0 then n=1 -> done after 1 edge each, result=1, overflow=0.
- SIZE=8, SATURATE=0, n=6 -> overflow=1 from the 4th multiply (120*3); final result=208 after 6 edges.
- SIZE=8, SATURATE=1, n=6 -> done asserts 4 edges after accept; result=255, overflow=1.
- n=5, abort pulsed on the 2nd MULT edge with go=0 -> state IDLE next edge, done=0, busy=0; a subsequent go with n=3 gives result=6.
- rst_n pulsed low mid-MULT (asynchronously, between edges) -> outputs reset immediately; after release, n=4 gives result=24 with normal latency.
